// File: rtl/nn_pkg.sv
// Types and helpers shared by the network layers.
package nn_pkg;

   typedef enum logic [1:0] {
      ActNone,
      ActRelu,
      ActSigmoid,
      ActTanh
   } activation_type;

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StDone
   } argmax_state_t;

   // Width able to address n items, never narrower than one bit.
   function automatic int unsigned index_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/argmax_layer_if.sv
// Vector-in / result-out bundle of the argmax readout stage.
interface argmax_layer_if
   import nn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_INPUTS = 10
) ();

   localparam int unsigned INDEX_WIDTH = index_width(NUM_INPUTS);

   logic                                   inputs_ready;
   logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0]  inputs;
   logic [INDEX_WIDTH-1:0]                 result_index;
   logic signed [DATA_WIDTH-1:0]           result_value;
   logic                                   result_ready;
   logic                                   busy;

   modport master (
      output inputs_ready, inputs,
      input  result_index, result_value, result_ready, busy
   );

   modport slave (
      input  inputs_ready, inputs,
      output result_index, result_value, result_ready, busy
   );

endinterface

// File: rtl/argmax_layer.sv
// Sequential argmax: captures a vector, scans one element per cycle and
// pulses result_ready with the index/value of the largest signed element.
module argmax_layer
   import nn_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_INPUTS = 10
) (
   input  logic          clock,
   input  logic          reset,
   argmax_layer_if.slave bus
);

   localparam int unsigned INDEX_WIDTH = index_width(NUM_INPUTS);

   typedef logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] vec_t;

   argmax_state_t                state_q, state_d;
   vec_t                         buf_q, buf_d;
   logic [INDEX_WIDTH-1:0]       cnt_q, cnt_d;
   logic [INDEX_WIDTH-1:0]       idx_q, idx_d;
   logic signed [DATA_WIDTH-1:0] val_q, val_d;
   logic                         ready_q, busy_q;
   logic [DATA_WIDTH-1:0]        elem;

   // Element under comparison; index 0 is never scanned, it seeds the maximum.
   always_comb begin
      elem = '0;
      for (int i = 1; i < NUM_INPUTS; i++) begin
         if (cnt_q == INDEX_WIDTH'(i)) elem = buf_q[i];
      end
   end

   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      val_d   = val_q;
      unique case (state_q)
         StIdle: begin
            if (bus.inputs_ready) begin
               buf_d   = bus.inputs;
               val_d   = bus.inputs[0];
               idx_d   = '0;
               cnt_d   = INDEX_WIDTH'(1);
               state_d = (NUM_INPUTS > 1) ? StScan : StDone;
            end
         end
         StScan: begin
            // Strictly greater only, so ties keep the lowest index.
            if ($signed(elem) > val_q) begin
               val_d = elem;
               idx_d = cnt_q;
            end
            cnt_d = cnt_q + INDEX_WIDTH'(1);
            if (cnt_q == INDEX_WIDTH'(NUM_INPUTS - 1)) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         buf_q   <= '0;
         cnt_q   <= '0;
         idx_q   <= '0;
         val_q   <= '0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         val_q   <= val_d;
         ready_q <= (state_d == StDone);
         busy_q  <= (state_d != StIdle);
      end
   end

   assign bus.result_index = idx_q;
   assign bus.result_value = val_q;
   assign bus.result_ready = ready_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_argmax_layer.sv
// Directed bench for argmax_layer: a 10-class instance and a 1-class instance.
module tb_argmax_layer;

   logic clock;
   logic reset;
   int   checks;
   int   failures;

   argmax_layer_if #(.DATA_WIDTH(32), .NUM_INPUTS(10)) a_if ();
   argmax_layer_if #(.DATA_WIDTH(32), .NUM_INPUTS(1))  b_if ();

   argmax_layer #(.DATA_WIDTH(32), .NUM_INPUTS(10)) u_a (
      .clock (clock),
      .reset (reset),
      .bus   (a_if)
   );

   argmax_layer #(.DATA_WIDTH(32), .NUM_INPUTS(1)) u_b (
      .clock (clock),
      .reset (reset),
      .bus   (b_if)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_vec(input int v[10]);
      for (int i = 0; i < 10; i++) a_if.inputs[i] = v[i];
   endtask

   // One-cycle strobe, then watch for the single result pulse 9 edges later.
   task automatic classify(input string tag, input int exp_idx, input int exp_val);
      int          lat;
      int          pulses;
      logic [63:0] got_idx;
      logic [63:0] got_val;
      lat     = -1;
      pulses  = 0;
      got_idx = '0;
      got_val = '0;
      a_if.inputs_ready = 1'b1;
      tick();
      a_if.inputs_ready = 1'b0;
      check({tag, "_busy_rise"}, a_if.busy, 1);
      for (int k = 1; k <= 16; k++) begin
         tick();
         if (a_if.result_ready) begin
            pulses++;
            if (lat < 0) begin
               lat     = k;
               got_idx = a_if.result_index;
               got_val = a_if.result_value;
            end
         end
      end
      check({tag, "_latency"}, lat, 9);
      check({tag, "_pulses"}, pulses, 1);
      check({tag, "_index"}, got_idx, exp_idx);
      check({tag, "_value"}, got_val, exp_val);
      check({tag, "_hold_value"}, a_if.result_value, exp_val);
      check({tag, "_busy_fall"}, a_if.busy, 0);
   endtask

   initial begin
      int v_mix[10];
      int v_neg[10];
      int v_ext[10];
      int v_alt[10];
      int pulses;
      checks   = 0;
      failures = 0;
      v_mix = '{3, -1, 7, 2, 7, 0, 0, 0, 0, -5};
      v_neg = '{-9, -4, -8, -4, -100, -9, -9, -9, -9, -9};
      v_ext = '{int'(32'h8000_0000), 0, 0, 0, 0, 0, 0, 0, 0, int'(32'h7FFF_FFFF)};
      v_alt = '{50, 50, 50, 50, 50, 50, 50, 50, 50, 50};

      reset             = 1'b0;
      a_if.inputs_ready = 1'b0;
      a_if.inputs       = '0;
      b_if.inputs_ready = 1'b0;
      b_if.inputs       = '0;
      tick();
      tick();
      check("rst_index", a_if.result_index, 0);
      check("rst_value", a_if.result_value, 0);
      check("rst_ready", a_if.result_ready, 0);
      check("rst_busy", a_if.busy, 0);
      check("rst_b_busy", b_if.busy, 0);
      reset = 1'b1;
      tick();

      set_vec(v_mix);
      classify("mix", 2, 7);
      set_vec(v_neg);
      classify("neg", 1, -4);
      set_vec(v_ext);
      classify("ext", 9, 32'h7FFF_FFFF);

      // Strobe held for 15 edges, vector swapped right after capture.
      set_vec(v_mix);
      a_if.inputs_ready = 1'b1;
      tick();
      set_vec(v_alt);
      pulses = 0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (a_if.result_ready) pulses++;
      end
      check("hold_early_ready", pulses, 0);
      tick();
      check("hold_ready", a_if.result_ready, 1);
      check("hold_index", a_if.result_index, 2);
      check("hold_value", a_if.result_value, 7);
      tick();
      check("hold_leave_done_busy", a_if.busy, 0);
      check("hold_leave_done_ready", a_if.result_ready, 0);
      tick();
      check("hold_recapture_busy", a_if.busy, 1);
      check("hold_recapture_value", a_if.result_value, 50);
      for (int k = 12; k <= 14; k++) tick();
      a_if.inputs_ready = 1'b0;
      pulses = 0;
      for (int k = 15; k <= 19; k++) begin
         tick();
         if (a_if.result_ready) pulses++;
      end
      check("hold2_early_ready", pulses, 0);
      tick();
      check("hold2_ready", a_if.result_ready, 1);
      check("hold2_index", a_if.result_index, 0);
      check("hold2_value", a_if.result_value, 50);
      tick();

      // Reset asserted during the third SCAN cycle.
      set_vec(v_mix);
      a_if.inputs_ready = 1'b1;
      tick();
      a_if.inputs_ready = 1'b0;
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      check("abort_busy", a_if.busy, 0);
      check("abort_ready", a_if.result_ready, 0);
      check("abort_value", a_if.result_value, 0);
      check("abort_index", a_if.result_index, 0);
      tick();
      tick();
      reset  = 1'b1;
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (a_if.result_ready) pulses++;
      end
      check("abort_no_result", pulses, 0);
      set_vec(v_neg);
      classify("post_reset", 1, -4);

      // Single-element instance: result right after the capture edge.
      b_if.inputs[0]    = -42;
      b_if.inputs_ready = 1'b1;
      tick();
      b_if.inputs_ready = 1'b0;
      check("n1_ready", b_if.result_ready, 1);
      check("n1_busy", b_if.busy, 1);
      check("n1_index", b_if.result_index, 0);
      check("n1_value", b_if.result_value, -42);
      tick();
      check("n1_ready_fall", b_if.result_ready, 0);
      check("n1_busy_fall", b_if.busy, 0);
      check("n1_hold_value", b_if.result_value, -42);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
